// File: rtl/posit_mult_arbiter_pkg.sv
// rtl/posit_mult_arbiter_pkg.sv - shared constants, clog2 helper and tag type for the posit multiplier arbiter
package posit_mult_arbiter_pkg;

    localparam int POSIT_N  = 32;
    localparam int POSIT_ES = 2;
    // Tag ID is sized for the largest supported requester count (8).
    localparam int TAG_IDW  = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/posit_mult_arbiter_if.sv
// rtl/posit_mult_arbiter_if.sv - requester and multiplier bus seen by the posit multiplier arbiter
interface posit_mult_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_in1;
    logic [NREQ*N-1:0] req_in2;
    logic [N-1:0]      mul_in1;
    logic [N-1:0]      mul_in2;
    logic              mul_start;
    logic [N-1:0]      mul_result;
    logic              mul_inf;
    logic              mul_zero;
    logic [NREQ-1:0]   rsp_valid;
    logic [N-1:0]      rsp_result;
    logic              rsp_inf;
    logic              rsp_zero;

    // slave: the arbiter itself; master: requesters plus multiplier
    modport slave (
        input  req_valid, req_in1, req_in2, mul_result, mul_inf, mul_zero,
        output req_ready, mul_in1, mul_in2, mul_start,
               rsp_valid, rsp_result, rsp_inf, rsp_zero
    );

    modport master (
        output req_valid, req_in1, req_in2, mul_result, mul_inf, mul_zero,
        input  req_ready, mul_in1, mul_in2, mul_start,
               rsp_valid, rsp_result, rsp_inf, rsp_zero
    );

endinterface

// File: rtl/posit_mult_tagpipe.sv
// rtl/posit_mult_tagpipe.sv - LATENCY-deep shift of requester tags aligned with the multiplier pipeline
module posit_mult_tagpipe
    import posit_mult_arbiter_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_i,
    output tag_t tag_o
);

    generate
        if (LATENCY == 0) begin : g_pass
            assign tag_o = tag_i;
        end else begin : g_shift
            tag_t stage_q [LATENCY];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= tag_i;
                    for (int i = 1; i < LATENCY; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign tag_o = stage_q[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/posit_mult_arbiter.sv
// rtl/posit_mult_arbiter.sv - round-robin sharing of one pipelined posit multiplier among NREQ requesters
module posit_mult_arbiter
    import posit_mult_arbiter_pkg::*;
#(
    parameter int N       = POSIT_N,
    parameter int ES      = POSIT_ES,
    parameter int NREQ    = 4,
    parameter int LATENCY = 4,
    parameter int IDW     = clog2(NREQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    posit_mult_arbiter_if.slave           bus,
    output logic                          busy,
    output logic [clog2(LATENCY+3)-1:0]   inflight
);

    localparam int CNTW = clog2(LATENCY + 3);

    generate
        if (IDW != clog2(NREQ) || NREQ < 2 || NREQ > 8 || ES < 0) begin : g_bad_params
            $error("posit_mult_arbiter: unsupported NREQ/IDW/ES combination");
        end
    endgenerate

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] grant_d;
    logic [IDW-1:0]  grant_id_d;
    logic            accept;
    int              idx;

    logic            mul_start_q;
    logic [N-1:0]    mul_in1_q, mul_in2_q;
    logic [IDW-1:0]  issue_id_q;

    tag_t            tag_in, tag_out;

    logic [NREQ-1:0] rsp_valid_q;
    logic [N-1:0]    rsp_result_q;
    logic            rsp_inf_q, rsp_zero_q;
    logic [CNTW-1:0] inflight_q;
    logic            rsp_any;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        grant_d    = '0;
        grant_id_d = '0;
        accept     = 1'b0;
        idx        = 0;
        if (enable) begin
            for (int i = 0; i < NREQ; i++) begin
                idx = (int'(ptr_q) + i) % NREQ;
                if (!accept && bus.req_valid[idx]) begin
                    accept       = 1'b1;
                    grant_d[idx] = 1'b1;
                    grant_id_d   = IDW'(idx);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant_id_d == IDW'(NREQ - 1)) ? '0 : grant_id_d + IDW'(1);
        end
    end

    always_comb begin
        tag_in.valid = mul_start_q;
        tag_in.id    = TAG_IDW'(issue_id_q);
    end

    posit_mult_tagpipe #(
        .LATENCY (LATENCY)
    ) u_tagpipe (
        .clk   (clk),
        .reset (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign rsp_any = |rsp_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= '0;
            mul_start_q  <= 1'b0;
            mul_in1_q    <= '0;
            mul_in2_q    <= '0;
            issue_id_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_inf_q    <= 1'b0;
            rsp_zero_q   <= 1'b0;
            inflight_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mul_start_q <= accept;
            if (accept) begin
                mul_in1_q  <= bus.req_in1[int'(grant_id_d)*N +: N];
                mul_in2_q  <= bus.req_in2[int'(grant_id_d)*N +: N];
                issue_id_q <= grant_id_d;
            end

            rsp_valid_q <= '0;
            if (tag_out.valid) begin
                rsp_valid_q  <= NREQ'(1) << tag_out.id;
                rsp_result_q <= bus.mul_result;
                rsp_inf_q    <= bus.mul_inf;
                rsp_zero_q   <= bus.mul_zero;
            end

            if (accept && !rsp_any) begin
                inflight_q <= inflight_q + CNTW'(1);
            end else if (!accept && rsp_any) begin
                inflight_q <= inflight_q - CNTW'(1);
            end
        end
    end

    assign bus.req_ready  = grant_d;
    assign bus.mul_start  = mul_start_q;
    assign bus.mul_in1    = mul_in1_q;
    assign bus.mul_in2    = mul_in2_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_inf    = rsp_inf_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign inflight       = inflight_q;
    assign busy           = |inflight_q;

endmodule

// File: tb/tb_posit_mult_arbiter.sv
// tb/tb_posit_mult_arbiter.sv - scoreboard bench for posit_mult_arbiter with a behavioural multiplier stand-in
module tb_posit_mult_arbiter;

    localparam int N       = 32;
    localparam int NREQ    = 4;
    localparam int LATENCY = 4;
    localparam int CNTW    = 3;
    localparam logic [31:0] ONE = 32'h4000_0000;
    localparam logic [31:0] NAR = 32'h8000_0000;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        inf;
        logic        zero;
        int          due;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            busy;
    logic [CNTW-1:0] inflight;

    posit_mult_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

    posit_mult_arbiter #(
        .N       (N),
        .ES      (2),
        .NREQ    (NREQ),
        .LATENCY (LATENCY),
        .IDW     (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .bus      (bus),
        .busy     (busy),
        .inflight (inflight)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   mptr   = 0;
    int   minfl  = 0;
    exp_t sbq [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in multiplier: exact for 1.0 operands, zero and NaR; arbitrary mix otherwise.
    function automatic logic [33:0] mockmul(input logic [31:0] a, input logic [31:0] b);
        logic        inf, zero;
        logic [31:0] r;
        inf  = (a == NAR) || (b == NAR);
        zero = !inf && ((a == 32'h0) || (b == 32'h0));
        if (inf)           r = NAR;
        else if (zero)     r = 32'h0;
        else if (a == ONE) r = b;
        else if (b == ONE) r = a;
        else               r = a ^ {b[15:0], b[31:16]};
        return {inf, zero, r};
    endfunction

    logic [33:0] mpipe [LATENCY];
    always @(posedge clk) begin
        mpipe[0] <= mockmul(bus.mul_in1, bus.mul_in2);
        for (int i = 1; i < LATENCY; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mul_result = mpipe[LATENCY-1][31:0];
    assign bus.mul_zero   = mpipe[LATENCY-1][32];
    assign bus.mul_inf    = mpipe[LATENCY-1][33];

    // Reference round-robin model plus response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        logic [NREQ-1:0] mg;
        int              mid;
        int              k;
        bit              rsp_due;
        exp_t            e;
        if (!reset) begin
            mg  = '0;
            mid = 0;
            if (enable) begin
                for (int i = 0; i < NREQ; i++) begin
                    k = (mptr + i) % NREQ;
                    if (mg == '0 && bus.req_valid[k]) begin
                        mg[k] = 1'b1;
                        mid   = k;
                    end
                end
            end
            checks++;
            if (bus.req_ready !== mg) begin
                errors++;
                $display("FAIL grant cyc=%0d got %b want %b", cyc, bus.req_ready, mg);
            end

            rsp_due = (sbq.size() != 0) && (sbq[0].due == cyc);
            checks++;
            if (rsp_due) begin
                e = sbq.pop_front();
                if (bus.rsp_valid !== 4'(1 << e.id) || bus.rsp_result !== e.res ||
                    bus.rsp_inf !== e.inf || bus.rsp_zero !== e.zero) begin
                    errors++;
                    $display("FAIL response cyc=%0d got v=%b r=%h i=%b z=%b want v=%b r=%h i=%b z=%b",
                             cyc, bus.rsp_valid, bus.rsp_result, bus.rsp_inf, bus.rsp_zero,
                             4'(1 << e.id), e.res, e.inf, e.zero);
                end
            end else if (bus.rsp_valid !== '0) begin
                errors++;
                $display("FAIL unexpected_rsp cyc=%0d got v=%b want 0000", cyc, bus.rsp_valid);
            end

            checks++;
            if (inflight !== CNTW'(minfl) || busy !== (minfl != 0)) begin
                errors++;
                $display("FAIL inflight cyc=%0d got %0d busy=%b want %0d busy=%b",
                         cyc, inflight, busy, minfl, (minfl != 0));
            end

            if (mg != '0) begin
                e.id   = mid;
                {e.inf, e.zero, e.res} = mockmul(bus.req_in1[mid*N +: N], bus.req_in2[mid*N +: N]);
                e.due  = cyc + LATENCY + 2;
                sbq.push_back(e);
                mptr = (mid + 1) % NREQ;
            end
            minfl = minfl + ((mg != '0) ? 1 : 0) - (rsp_due ? 1 : 0);
        end
    end

    task automatic randomize_ops();
        for (int k = 0; k < NREQ; k++) begin
            bus.req_in1[k*N +: N] = $urandom;
            bus.req_in2[k*N +: N] = $urandom;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_%s got %0d pending want 0", name, sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        bus.req_valid = '0;
        randomize_ops();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.mul_start !== 1'b0 || bus.mul_in1 !== '0 || bus.mul_in2 !== '0 ||
            bus.rsp_valid !== '0 || bus.rsp_result !== '0 || inflight !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got start=%b in1=%h rv=%b rr=%h infl=%0d busy=%b want all 0",
                     bus.mul_start, bus.mul_in1, bus.rsp_valid, bus.rsp_result, inflight, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_all_valid();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus.req_valid = 4'b1111;
            randomize_ops();
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 4'(1 << (i % 4))) begin
                errors++;
                $display("FAIL rr_all step=%0d got %b want %b", i, bus.req_ready, 4'(1 << (i % 4)));
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_drain("all_valid");
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        bus.req_valid = 4'b0100;
        bus.req_in1[2*N +: N] = 32'h4000_0000;
        bus.req_in2[2*N +: N] = 32'h4800_0000;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant got %b want 0100", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        checks++;
        if (bus.mul_start !== 1'b1 || bus.mul_in1 !== 32'h4000_0000 || bus.mul_in2 !== 32'h4800_0000) begin
            errors++;
            $display("FAIL single_issue got start=%b in1=%h in2=%h want 1 40000000 48000000",
                     bus.mul_start, bus.mul_in1, bus.mul_in2);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_result !== 32'h4800_0000) begin
            errors++;
            $display("FAIL single_rsp got v=%b r=%h want 0100 48000000", bus.rsp_valid, bus.rsp_result);
        end
        @(negedge clk);
        checks++;
        if (inflight !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got infl=%0d busy=%b want 0 0", inflight, busy);
        end
        wait_drain("single");
    endtask

    task automatic test_pointer();
        logic [3:0] want [3];
        want[0] = 4'b1000;
        want[1] = 4'b0010;
        want[2] = 4'b1000;
        @(posedge clk); #1;
        bus.req_valid = 4'b0010;
        randomize_ops();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.req_valid = 4'b1010;
            randomize_ops();
            @(negedge clk);
            checks++;
            if (bus.req_ready !== want[i]) begin
                errors++;
                $display("FAIL rr_ptr2 step=%0d got %b want %b", i, bus.req_ready, want[i]);
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_drain("pointer");
    endtask

    task automatic test_enable_drop();
        int pulses;
        pulses = 0;
        @(posedge clk); #1;
        bus.req_valid = 4'b1111;
        randomize_ops();
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== '0 || busy !== (pulses < 3)) begin
                errors++;
                $display("FAIL enable_drop step=%0d got ready=%b busy=%b want 0000 %b",
                         i, bus.req_ready, busy, (pulses < 3));
            end
            if (bus.rsp_valid != '0) pulses++;
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL enable_pulses got %0d want 3", pulses);
        end
        bus.req_valid = '0;
        enable = 1'b1;
        wait_drain("enable");
    endtask

    task automatic test_special();
        logic [31:0] a [2];
        logic [31:0] b [2];
        int          r [2];
        a[0] = 32'h0;      b[0] = 32'h4000_0000; r[0] = 1;
        a[1] = 32'h8000_0000; b[1] = 32'h4800_0000; r[1] = 3;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            bus.req_in1[r[t]*N +: N] = a[t];
            bus.req_in2[r[t]*N +: N] = b[t];
            bus.req_valid = 4'(1 << r[t]);
            @(posedge clk); #1;
            bus.req_valid = '0;
            repeat (6) @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 4'(1 << r[t]) || bus.rsp_zero !== (t == 0) || bus.rsp_inf !== (t == 1)) begin
                errors++;
                $display("FAIL special_%0d got v=%b z=%b i=%b want v=%b z=%b i=%b", t,
                         bus.rsp_valid, bus.rsp_zero, bus.rsp_inf, 4'(1 << r[t]), (t == 0), (t == 1));
            end
            wait_drain("special");
        end
    endtask

    task automatic test_reset_midflight();
        int pulses;
        pulses = 0;
        @(posedge clk); #1;
        bus.req_valid = 4'b1111;
        randomize_ops();
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = '0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== '0 || bus.mul_start !== 1'b0 || bus.mul_in1 !== '0 || bus.mul_in2 !== '0 ||
            bus.rsp_valid !== '0 || bus.rsp_result !== '0 || inflight !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b start=%b in1=%h rv=%b infl=%0d busy=%b want all 0",
                     bus.req_ready, bus.mul_start, bus.mul_in1, bus.rsp_valid, inflight, busy);
        end
        sbq.delete();
        mptr  = 0;
        minfl = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_no_rsp got %0d pulses want 0", pulses);
        end
        @(posedge clk); #1;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant got %b want 0001", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_all_valid();
        test_single();
        test_pointer();
        test_enable_drop();
        test_special();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/posit_mult_arbiter.md
Name: posit_mult_arbiter

Overview:
- Shares one pipelined 32-bit posit multiplier (es=2) among NREQ requesters, e.g. the PairHMM PE lanes.
- Arbitrates requests round-robin, issues operands with a start strobe, and carries each requester's ID through a tag pipeline matched to the multiplier latency.
- Returns each result to the requester that issued it, with a per-requester valid strobe.
- Sits between the PE datapath and the posit multiplier instance.

Parameters:
N, 32, posit word width
ES, 2, posit exponent size (passed through, not used in logic)
NREQ, 4, number of requesters (2..8)
LATENCY, 4, multiplier cycles from start to result (0 = combinational)
IDW, 2, requester-ID width, equal to clog2(NREQ)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = arbitration allowed; 0 = accept nothing, in-flight operations drain
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  one-hot grant; at most one bit set
req_in1  in  NREQ*N  flattened operand A; slice k belongs to requester k
req_in2  in  NREQ*N  flattened operand B
mul_in1  out  N  operand A to the multiplier
mul_in2  out  N  operand B to the multiplier
mul_start  out  1  issue strobe to the multiplier
mul_result  in  N  multiplier result
mul_inf  in  1  multiplier NaR/infinity flag
mul_zero  in  1  multiplier zero flag
rsp_valid  out  NREQ  one-hot result strobe, one cycle per result
rsp_result  out  N  result word, shared by all requesters
rsp_inf  out  1  registered copy of mul_inf
rsp_zero  out  1  registered copy of mul_zero
busy  out  1  1 while any operation is in flight or a response is pending
inflight  out  IDW+LATENCY-width-safe counter  number of operations issued and not yet responded; counter width is clog2(LATENCY+3)

Behaviour:
- Reset (asynchronous): all outputs are 0, including mul_in1/2, rsp_result and inflight. Round-robin pointer resets to 0. Tag pipeline is cleared.
- Grant (combinational):
  - When enable=1, req_ready[k]=1 for the first k with req_valid[k]=1, searching from the pointer upward with wrap-around.
  - When enable=0, or no request is valid, req_ready=0.
- Accept = |(req_valid & req_ready).
- On accept:
  - Pointer becomes (granted k + 1) mod NREQ.
  - The pointer does not move when there is no accept.
- Issue (registered):
  - The cycle after an accept: mul_start=1, and mul_in1/mul_in2 hold slice k of req_in1/req_in2.
  - On a cycle with no accept, mul_start=0 and mul_in1/mul_in2 hold their previous value.
  - Throughput is one operation per cycle, with no bubbles.
- Tag pipeline:
  - LATENCY-deep shift of {valid, id}, loaded together with mul_start.
  - The tag exits on the same cycle the multiplier presents the matching result.
  - When LATENCY=0, the tag is taken directly from the issue register.
- Response (registered):
  - On the cycle after the tag exits with valid=1: rsp_valid[id]=1, and rsp_result, rsp_inf and rsp_zero are the sampled mul_* values.
  - Otherwise rsp_valid=0 and the data outputs hold their value.
  - Requesters cannot back-pressure; every requester must accept its rsp_valid pulse.
- Total latency from the accept edge to rsp_valid is LATENCY+2 cycles.
- inflight counter:
  - +1 on accept, -1 on rsp_valid, and unchanged when both happen in the same cycle.
  - Never wraps; it is bounded by LATENCY+2.
- busy = (inflight != 0).
- Deassertion of enable mid-stream: operations already accepted still complete and respond, in issue order.
- Reset mid-operation: all in-flight operations are discarded and no rsp_valid is produced for them.
- A requester may request again immediately after its grant; round-robin still rotates to the others first if they are valid.

Decomposition:
- Shared package: posit width constants (N=32, ES=2), the clog2 function, and the tag struct {valid, id[IDW-1:0]}.
- Natural sub-module: posit_mult_tagpipe, a parameterised LATENCY-deep shift register of tags, with a pass-through case for LATENCY=0.
- The multiplier is instantiated outside this block, by the PE array top.

Test Plan:
1. Single request, LATENCY=4: requester 2 sends in1=0x40000000 (1.0), in2=0x48000000 (2.0).
   -> mul_start one cycle later; rsp_valid=4'b0100 and rsp_result=0x48000000 exactly 6 cycles after accept; inflight returns to 0.
2. All four requesters valid continuously, pointer=0:
   -> grants 0,1,2,3,0,… one per cycle; responses come back in the same order with 4'b0001,4'b0010,… and no gaps.
3. Requesters 1 and 3 valid, pointer=2:
   -> 3 is granted first, then 1, then 3.
4. enable dropped after 3 accepts:
   -> req_ready=0 from that cycle; exactly 3 rsp_valid pulses follow; busy stays 1 until the last pulse, then goes 0.
5. Zero and NaR: in1=0x00000000 gives rsp_zero=1; in1=0x80000000 gives rsp_inf=1, routed to the correct requester.
6. reset asserted with 3 in flight:
   -> all outputs go 0 immediately; no rsp_valid after release; inflight=0; the first grant after release goes to requester 0.
